// File: rtl/wave_pkg.sv
`default_nettype none
// ============================================================================
// Module : wave_pkg
// Brief  : Shared widths, frame length and FSM encodings for wave_timebase.
// Rev    : 1.0  initial release
// ============================================================================
package wave_pkg;

    localparam int DATA_W    = 8;
    localparam int N_STEPS   = 8;
    localparam int FRAME_LEN = 750;
    localparam int IDX_W     = 3;
    localparam int ACC_W     = DATA_W + N_STEPS - 1;
    localparam int CNT_W     = N_STEPS - 1;
    localparam int FRM_W     = 10;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // Index of the last sample in a 2^idx window.
    function automatic logic [CNT_W-1:0] win_last(input logic [IDX_W-1:0] idx);
        logic [CNT_W:0] w_one;
        logic [CNT_W:0] w_len;
        w_one = {{CNT_W{1'b0}}, 1'b1};
        w_len = (w_one << idx) - w_one;
        return w_len[CNT_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/wave_win_acc.sv
`default_nettype none
// ============================================================================
// Module : wave_win_acc
// Brief  : 2^idx sample window counter and accumulator; strobes o_done with the
//          window average (or peak when WAVE_PEAK_DET_EN is defined).
// Rev    : 1.0  initial release
// ============================================================================
module wave_win_acc
    import wave_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic              i_clear,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
`ifdef WAVE_PEAK_DET_EN
    input  logic              i_peak_mode,
`endif
    output logic              o_done,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_result
);

    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_take;
    logic              w_last;
    logic [ACC_W-1:0]  w_sum;
    logic [DATA_W-1:0] w_avg;

    assign w_take  = i_valid && !i_clear;
    assign w_last  = (r_cnt == win_last(i_idx));
    assign w_sum   = r_acc + {{(ACC_W-DATA_W){1'b0}}, i_data};
    assign w_avg   = DATA_W'(w_sum >> i_idx);
    assign o_done  = w_take && w_last;
    assign o_empty = (r_cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_clear || (w_take && w_last)) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_take) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

`ifdef WAVE_PEAK_DET_EN
    logic [DATA_W-1:0] r_max;
    logic              r_mode;
    logic              w_mode;
    logic [DATA_W-1:0] w_max;

    // Mode is sampled with the first sample of a window and held for the rest.
    assign w_mode   = o_empty ? i_peak_mode : r_mode;
    assign w_max    = (o_empty || (i_data > r_max)) ? i_data : r_max;
    assign o_result = w_mode ? w_max : w_avg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_max  <= '0;
            r_mode <= 1'b0;
        end else if (i_clear || (w_take && w_last)) begin
            r_max  <= '0;
            r_mode <= 1'b0;
        end else if (w_take) begin
            r_max  <= w_max;
            r_mode <= w_mode;
        end
    end
`else
    assign o_result = w_avg;
`endif

endmodule
`default_nettype wire

// File: rtl/wave_timebase.sv
`default_nettype none
// ============================================================================
// Module : wave_timebase
// Brief  : ADC decimation timebase with step control and frame-aligned hold.
//          Optional peak-detect mode enabled by WAVE_PEAK_DET_EN.
// Rev    : 1.0  initial release
// ============================================================================
module wave_timebase
    import wave_pkg::*;
(
    input  logic              I_wave_clk,
    input  logic              I_wave_rstn,
    input  logic [DATA_W-1:0] I_adc_data,
    input  logic              I_adc_valid,
    input  logic              I_step_up,
    input  logic              I_step_down,
    input  logic              I_hold,
`ifdef WAVE_PEAK_DET_EN
    input  logic              I_peak_mode,
`endif
    output logic [DATA_W-1:0] O_wave_data,
    output logic              O_wave_data_de,
    output logic [IDX_W-1:0]  O_step_idx,
    output logic              O_frame_done,
    output logic              O_holding
);

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [FRM_W-1:0]  r_frame;
    logic [DATA_W-1:0] r_data;
    logic              r_de;
    logic              r_fd;
    logic              r_holding;

    logic              w_up_eff;
    logic              w_dn_eff;
    logic              w_direct_hold;
    logic              w_clear;
    logic              w_done;
    logic              w_empty;
    logic              w_frame_end;
    logic [DATA_W-1:0] w_result;

    assign w_up_eff      = I_step_up && !I_step_down && (r_idx != IDX_W'(N_STEPS - 1));
    assign w_dn_eff      = I_step_down && !I_step_up && (r_idx != '0);
    // Nothing in flight: hold can take effect without draining a frame.
    assign w_direct_hold = (r_state == S_RUN) && I_hold && (r_frame == '0) && w_empty;
    assign w_clear       = w_up_eff || w_dn_eff || (r_state == S_HOLD) || w_direct_hold;
    assign w_frame_end   = w_done && (r_frame == FRM_W'(FRAME_LEN - 1));

    wave_win_acc u_win_acc (
        .i_clk       (I_wave_clk),
        .i_rst_n     (I_wave_rstn),
        .i_idx       (r_idx),
        .i_clear     (w_clear),
        .i_valid     (I_adc_valid),
        .i_data      (I_adc_data),
`ifdef WAVE_PEAK_DET_EN
        .i_peak_mode (I_peak_mode),
`endif
        .o_done      (w_done),
        .o_empty     (w_empty),
        .o_result    (w_result)
    );

    always_ff @(posedge I_wave_clk or negedge I_wave_rstn) begin
        if (!I_wave_rstn) begin
            r_state   <= S_RUN;
            r_idx     <= '0;
            r_frame   <= '0;
            r_data    <= '0;
            r_de      <= 1'b0;
            r_fd      <= 1'b0;
            r_holding <= 1'b0;
        end else begin
            r_de <= w_done;
            r_fd <= w_frame_end;
            if (w_done) begin
                r_data <= w_result;
            end

            if (w_up_eff) begin
                r_idx <= r_idx + IDX_W'(1);
            end else if (w_dn_eff) begin
                r_idx <= r_idx - IDX_W'(1);
            end

            if ((r_state == S_HOLD) || w_direct_hold || w_frame_end) begin
                r_frame <= '0;
            end else if (w_done) begin
                r_frame <= r_frame + FRM_W'(1);
            end

            case (r_state)
                S_RUN: begin
                    if (I_hold && (w_direct_hold || w_frame_end)) begin
                        r_state   <= S_HOLD;
                        r_holding <= 1'b1;
                    end else if (I_hold) begin
                        r_state   <= S_DRAIN;
                        r_holding <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (!I_hold) begin
                        r_state   <= S_RUN;
                        r_holding <= 1'b0;
                    end else if (w_frame_end) begin
                        r_state   <= S_HOLD;
                        r_holding <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!I_hold) begin
                        r_state   <= S_RUN;
                        r_holding <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_RUN;
                    r_holding <= 1'b0;
                end
            endcase
        end
    end

    assign O_wave_data    = r_data;
    assign O_wave_data_de = r_de;
    assign O_step_idx     = r_idx;
    assign O_frame_done   = r_fd;
    assign O_holding      = r_holding;

endmodule
`default_nettype wire

// File: tb/tb_wave_timebase.sv
`default_nettype none
// ============================================================================
// Module : tb_wave_timebase
// Brief  : Directed and randomized bench for wave_timebase against a
//          window/queue reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_wave_timebase;

    localparam int DATA_W    = 8;
    localparam int N_STEPS   = 8;
    localparam int FRAME_LEN = 750;
`ifdef WAVE_PEAK_DET_EN
    localparam bit PEAK = 1'b1;
`else
    localparam bit PEAK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstn;
    logic [DATA_W-1:0] I_adc_data;
    logic              I_adc_valid;
    logic              I_step_up;
    logic              I_step_down;
    logic              I_hold;
`ifdef WAVE_PEAK_DET_EN
    logic              I_peak_mode;
`endif
    logic [DATA_W-1:0] O_wave_data;
    logic              O_wave_data_de;
    logic [2:0]        O_step_idx;
    logic              O_frame_done;
    logic              O_holding;

    always #5 clk = ~clk;

    wave_timebase dut (
        .I_wave_clk     (clk),
        .I_wave_rstn    (rstn),
        .I_adc_data     (I_adc_data),
        .I_adc_valid    (I_adc_valid),
        .I_step_up      (I_step_up),
        .I_step_down    (I_step_down),
        .I_hold         (I_hold),
`ifdef WAVE_PEAK_DET_EN
        .I_peak_mode    (I_peak_mode),
`endif
        .O_wave_data    (O_wave_data),
        .O_wave_data_de (O_wave_data_de),
        .O_step_idx     (O_step_idx),
        .O_frame_done   (O_frame_done),
        .O_holding      (O_holding)
    );

    int checks   = 0;
    int failures = 0;
    int de_cnt   = 0;
    int fd_at    = -1;

    // Reference model: pending window samples, frame position, hold request phase.
    int m_idx;
    int m_win[$];
    bit m_mode;
    int m_frame;
    bit m_drain;
    bit m_hold;
    int e_data;
    bit e_de;
    bit e_fd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idx = 0; m_win.delete(); m_mode = 0; m_frame = 0;
        m_drain = 0; m_hold = 0; e_data = 0; e_de = 0; e_fd = 0;
    endtask

    task automatic model_step(input bit up, input bit dn, input bit v, input int d,
                              input bit h, input bit pk);
        bit eff, boundary;
        int sum, mx;
        eff = (up != dn) && (up ? (m_idx < N_STEPS - 1) : (m_idx > 0));
        e_de = 0; e_fd = 0; boundary = 0;
        if (m_hold) begin
            m_win.delete();
            m_frame = 0;
            m_drain = 0;
            if (!h) m_hold = 0;
        end else if (!m_drain && h && m_frame == 0 && m_win.size() == 0) begin
            m_hold = 1;
        end else begin
            if (eff) begin
                m_win.delete();
            end else if (v) begin
                if (m_win.size() == 0) m_mode = pk;
                m_win.push_back(d);
                if (m_win.size() == (1 << m_idx)) begin
                    sum = 0; mx = 0;
                    foreach (m_win[i]) begin
                        sum += m_win[i];
                        if (m_win[i] > mx) mx = m_win[i];
                    end
                    e_data = m_mode ? mx : sum / (1 << m_idx);
                    e_de = 1;
                    m_win.delete();
                    if (m_frame == FRAME_LEN - 1) begin
                        e_fd = 1; m_frame = 0; boundary = 1;
                    end else begin
                        m_frame++;
                    end
                end
            end
            m_hold  = h && boundary;
            m_drain = h && !boundary;
        end
        if (eff) m_idx = up ? m_idx + 1 : m_idx - 1;
    endtask

    task automatic check_cycle();
        chk("de",         O_wave_data_de, e_de);
        chk("data",       O_wave_data,    e_data);
        chk("frame_done", O_frame_done,   e_fd);
        chk("holding",    O_holding,      m_hold);
        chk("step_idx",   O_step_idx,     m_idx);
        if (O_wave_data_de === 1'b1) de_cnt++;
        if (O_frame_done === 1'b1) fd_at = de_cnt;
    endtask

    task automatic cyc(input bit up, input bit dn, input bit v, input int d,
                       input bit h, input bit pk);
        I_step_up   = up;
        I_step_down = dn;
        I_adc_valid = v;
        I_adc_data  = d[DATA_W-1:0];
        I_hold      = h;
`ifdef WAVE_PEAK_DET_EN
        I_peak_mode = pk;
`endif
        model_step(up, dn, v, d, h, pk & PEAK);
        @(posedge clk);
        #1;
        check_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_data"},  O_wave_data, 0);
        chk({nm, "_de"},    O_wave_data_de, 0);
        chk({nm, "_idx"},   O_step_idx, 0);
        chk({nm, "_fd"},    O_frame_done, 0);
        chk({nm, "_hold"},  O_holding, 0);
    endtask

    task automatic do_reset();
        I_step_up = 0; I_step_down = 0; I_adc_valid = 0; I_adc_data = 0; I_hold = 0;
`ifdef WAVE_PEAK_DET_EN
        I_peak_mode = 0;
`endif
        rstn = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_zero("reset");
        rstn = 1;
    endtask

    initial begin
        int base, base2;
        bit h_lvl;

        // Ramp passthrough at idx=0
        do_reset();
        base = de_cnt;
        for (int i = 0; i < 256; i++) cyc(0, 0, 1, i, 0, 0);
        idle(1);
        chk("ramp_de_count", de_cnt - base, 256);
        chk("ramp_last", O_wave_data, 255);

        // Averaging over 8 samples with gaps
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
        base = de_cnt;
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 0, 1, 10 * k, 0, 0);
            cyc(0, 0, 0, $urandom_range(255, 0), 0, 0);
        end
        chk("avg8_de_count", de_cnt - base, 1);
        chk("avg8_data", O_wave_data, 45);

        // Step saturation and simultaneous pulses
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 0, 0);
        chk("sat_up", O_step_idx, 7);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 0, 0);
        chk("sat_up_again", O_step_idx, 7);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 0, 0);
        chk("sat_down", O_step_idx, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("up_and_down", O_step_idx, 3);

        // Partial window discarded on a step change
        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        base = de_cnt;
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 255, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) cyc(0, 0, 1, 10 * k, 0, 0);
        idle(1);
        chk("partial_de_count", de_cnt - base, 1);
        chk("partial_data", O_wave_data, 45);

        // Frame completion and hold/drain/release
        do_reset();
        base = de_cnt;
        for (int i = 0; i < 100; i++) cyc(0, 0, 1, $urandom_range(255, 0), 0, 0);
        base2 = de_cnt;
        begin
            int n;
            n = 0;
            while (O_holding !== 1'b1 && n < 2000) begin
                cyc(0, 0, 1, $urandom_range(255, 0), 1, 0);
                n++;
            end
            chk("drain_timeout", n < 2000, 1);
        end
        chk("drain_de_count", de_cnt - base2, 650);
        chk("frame_done_pos", fd_at - base, 750);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, $urandom_range(255, 0), 1, 0);
        base = de_cnt;
        cyc(0, 0, 1, 17, 0, 0);
        cyc(0, 0, 1, 33, 0, 0);
        chk("release_de_count", de_cnt - base, 1);
        chk("release_data", O_wave_data, 33);

        // Mid-window asynchronous reset
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 200, 0, 0);
        I_step_up = 0; I_step_down = 0; I_adc_valid = 0; I_hold = 0;
        rstn = 0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1;
        cyc(0, 0, 1, 9, 0, 0);
        chk("post_reset_data", O_wave_data, 9);

`ifdef WAVE_PEAK_DET_EN
        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 5, 0, 1);
        cyc(0, 0, 1, 200, 0, 1);
        cyc(0, 0, 1, 7, 0, 1);
        cyc(0, 0, 1, 9, 0, 1);
        idle(1);
        chk("peak_data", O_wave_data, 200);
        cyc(0, 0, 1, 5, 0, 0);
        cyc(0, 0, 1, 200, 0, 0);
        cyc(0, 0, 1, 7, 0, 0);
        cyc(0, 0, 1, 9, 0, 0);
        idle(1);
        chk("avg_mode_data", O_wave_data, 55);
        cyc(0, 0, 1, 5, 0, 1);
        cyc(0, 0, 1, 200, 0, 0);
        cyc(0, 0, 1, 7, 0, 0);
        cyc(0, 0, 1, 9, 0, 0);
        idle(1);
        chk("peak_mode_latched", O_wave_data, 200);
`endif

        // Randomized traffic
        do_reset();
        h_lvl = 0;
        for (int i = 0; i < 20000; i++) begin
            bit up, dn, v, pk;
            if ($urandom_range(399, 0) == 0) h_lvl = ~h_lvl;
            up = ($urandom_range(99, 0) < 2);
            dn = ($urandom_range(99, 0) < 3);
            v  = ($urandom_range(99, 0) < 75);
            pk = $urandom_range(1, 0);
            cyc(up, dn, v, $urandom_range(255, 0), h_lvl, pk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
